ws2812_frame_buffer_ctrl: RTL and testbench
===========================================

Name: ws2812_frame_buffer_ctrl

Overview:
Double-buffered pixel store and swap scheduler that sits between the host/bus pixel writer and the ws2812 serializer. The host fills the back buffer through a valid/ready write port. A swap request is held pending and executed only at the serializer's frame boundary, so the strip never shows a torn frame. The serializer reads the front buffer through its pixel address with one cycle of registered-read latency.

Parameters:
LED_COUNT, 256, number of pixels per buffer (1..512)
ADDR_WIDTH, 9, pixel address width; must satisfy LED_COUNT <= 2^ADDR_WIDTH

Ports:
clk_i  in  1  system clock
rst_i  in  1  reset
wr_valid_i  in  1  host pixel write request
wr_ready_o  out  1  write accepted when wr_valid_i && wr_ready_o
wr_addr_i  in  ADDR_WIDTH  back-buffer pixel index
wr_r_i / wr_g_i / wr_b_i  in  8 each  pixel colour
wr_err_o  out  1  one-cycle pulse: accepted write had wr_addr_i >= LED_COUNT
swap_req_i  in  1  pulse: request front/back exchange
swap_pending_o  out  1  swap requested, not yet executed
swap_done_o  out  1  one-cycle pulse in the cycle after the swap executes
frame_sync_i  in  1  one-cycle pulse from the serializer at frame end (entry to reset symbol)
drv_address_i  in  ADDR_WIDTH  serializer pixel address
r_o / g_o / b_o  out  8 each  front-buffer pixel data for serializer
front_sel_o  out  1  bank currently displayed (0/1)
init_busy_o  out  1  high during post-reset clear

Behaviour:
- Clocking and reset: single clock; reset is synchronous and active-high on rst_i.
- Reset values: state = CLEAR, front_sel_o = 0, wr_ready_o = 0, swap_pending_o = 0, swap_done_o = 0, wr_err_o = 0, r_o/g_o/b_o = 0, init_busy_o = 1, clear counter = 0.
- Storage: two banks, each LED_COUNT x 24 bits ({g, r, b}). Each bank has one write port and one synchronous read port.
- State CLEAR:
  - Writes zero to address clr_cnt in both banks; clr_cnt increments by 1 per cycle.
  - At clr_cnt == LED_COUNT-1, transition to IDLE (CLEAR lasts exactly LED_COUNT cycles).
  - wr_ready_o = 0; swap_req_i is ignored (not latched); r_o/g_o/b_o forced to 0.
- State IDLE:
  - wr_ready_o = 1; accepted writes go to bank ~front_sel_o.
  - If wr_addr_i >= LED_COUNT, the write is discarded and wr_err_o pulses on the next cycle.
  - swap_req_i transitions to PENDING. A write accepted in the same cycle as swap_req_i still lands in the back buffer.
  - frame_sync_i has no effect in IDLE. If swap_req_i and frame_sync_i coincide in IDLE, the swap waits for the next frame_sync_i.
- State PENDING:
  - swap_pending_o = 1; wr_ready_o = 0 (back buffer locked); further swap_req_i are ignored.
  - On frame_sync_i: front_sel_o toggles on that edge, the block returns to IDLE, and swap_done_o pulses in the following cycle.
  - No copy occurs between banks: after a swap, the new back buffer holds the frame displayed before it (two frames old).
- Read path:
  - r_o/g_o/b_o are registered from bank front_sel_o at drv_address_i.
  - Latency is 1 cycle: outputs at cycle n+1 reflect the address and front_sel at cycle n.
  - drv_address_i >= LED_COUNT returns 0.
  - The serializer samples pixel data no earlier than one bit period after an address change, so 1-cycle latency is acceptable.
- Reset mid-operation: any state returns to CLEAR, a pending swap is dropped, front_sel_o returns to 0, and both banks are re-zeroed.
- Arithmetic:
  - clr_cnt is ADDR_WIDTH bits.
  - Address comparisons against LED_COUNT are unsigned at ADDR_WIDTH+1 bits, so LED_COUNT = 2^ADDR_WIDTH is legal.

Test Plan:
1. Clear after reset: LED_COUNT = 8, release rst_i -> init_busy_o high for exactly 8 cycles, then wr_ready_o = 1; reads of address 0..7 return 0.
2. Write and swap: write addr 3 = {r=0x12, g=0x34, b=0x56}, pulse swap_req_i, then frame_sync_i 20 cycles later.
   - swap_pending_o is high for those 20 cycles and wr_ready_o is low.
   - front_sel_o = 1 after the frame_sync_i edge; swap_done_o pulses 1 cycle later.
   - drv_address_i = 3 gives r_o/g_o/b_o = 0x12/0x34/0x56 one cycle later.
3. Coincident events: swap_req_i and frame_sync_i in the same IDLE cycle -> no swap; front_sel_o unchanged until the next frame_sync_i.
4. Out-of-range write: LED_COUNT = 8, write to addr 9 -> accepted, wr_err_o pulses once, bank contents unchanged.
5. Back-buffer isolation: while showing bank 0, write addr 0 = 0xFFFFFF -> r_o/g_o/b_o for address 0 stay at the old value until a swap completes.
6. Reset during PENDING: assert rst_i with swap pending -> swap_pending_o = 0, front_sel_o = 0, CLEAR re-runs for LED_COUNT cycles, and a later frame_sync_i causes no swap.

Source files
------------

// File: rtl/ws2812_frame_buffer_ctrl.sv
// ws2812_frame_buffer_ctrl
//   Double-buffered pixel store sitting between the host pixel writer and the
//   ws2812 serializer. The host fills the back bank through a valid/ready
//   port. A swap request waits in PENDING until the serializer reports a frame
//   boundary, so the strip never shows a torn frame. After reset both banks
//   are zeroed one address per cycle before the block accepts traffic.
//
// Ports
//   clk_i, rst_i            clock, synchronous active-high reset
//   wr_valid_i/wr_ready_o   host write handshake (ready only in IDLE)
//   wr_addr_i, wr_r/g/b_i   back-bank pixel index and colour
//   wr_err_o                pulse: accepted write was out of range (dropped)
//   swap_req_i              pulse: request front/back exchange
//   swap_pending_o          swap requested, waiting for frame_sync_i
//   swap_done_o             pulse in the cycle after the swap executes
//   frame_sync_i            serializer frame-end pulse
//   drv_address_i           serializer pixel address
//   r_o/g_o/b_o             front-bank pixel, one cycle read latency
//   front_sel_o             bank currently displayed
//   init_busy_o             high while the post-reset clear runs
module ws2812_frame_buffer_ctrl #(
  parameter int unsigned LED_COUNT  = 256,
  parameter int unsigned ADDR_WIDTH = 9
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  wr_valid_i,
  output logic                  wr_ready_o,
  input  logic [ADDR_WIDTH-1:0] wr_addr_i,
  input  logic [7:0]            wr_r_i,
  input  logic [7:0]            wr_g_i,
  input  logic [7:0]            wr_b_i,
  output logic                  wr_err_o,
  input  logic                  swap_req_i,
  output logic                  swap_pending_o,
  output logic                  swap_done_o,
  input  logic                  frame_sync_i,
  input  logic [ADDR_WIDTH-1:0] drv_address_i,
  output logic [7:0]            r_o,
  output logic [7:0]            g_o,
  output logic [7:0]            b_o,
  output logic                  front_sel_o,
  output logic                  init_busy_o
);

  localparam int unsigned IDX_W = (LED_COUNT > 1) ? $clog2(LED_COUNT) : 1;
  localparam logic [ADDR_WIDTH:0]   LIMIT    = (ADDR_WIDTH+1)'(LED_COUNT);
  localparam logic [ADDR_WIDTH-1:0] CLR_LAST = ADDR_WIDTH'(LED_COUNT - 1);

  typedef enum logic [1:0] {
    ST_CLEAR,
    ST_IDLE,
    ST_PENDING
  } state_t;

  state_t state_q, state_d;

  // Each word is stored as {g, r, b}.
  logic [23:0] bank0_mem [LED_COUNT];
  logic [23:0] bank1_mem [LED_COUNT];

  logic [ADDR_WIDTH-1:0] clr_cnt_q;
  logic                  front_sel_q;
  logic                  swap_done_q;
  logic                  wr_err_q;
  logic [23:0]           rd_q;

  logic                  clear_we;
  logic                  swap_go;
  logic                  wr_accept;
  logic                  wr_in_range;
  logic                  host_we;
  logic                  bank0_we;
  logic                  bank1_we;
  logic [IDX_W-1:0]      waddr;
  logic [23:0]           wdata;
  logic                  drv_in_range;
  logic [IDX_W-1:0]      raddr;
  logic [23:0]           rd_word;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_CLEAR;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    wr_ready_o     = 1'b0;
    swap_pending_o = 1'b0;
    init_busy_o    = 1'b0;
    clear_we       = 1'b0;
    swap_go        = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        init_busy_o = 1'b1;
        clear_we    = 1'b1;
        if (clr_cnt_q == CLR_LAST) begin
          state_d = ST_IDLE;
        end
      end
      ST_IDLE: begin
        wr_ready_o = 1'b1;
        // frame_sync_i is ignored here even if it coincides with the request.
        if (swap_req_i) begin
          state_d = ST_PENDING;
        end
      end
      ST_PENDING: begin
        swap_pending_o = 1'b1;
        if (frame_sync_i) begin
          swap_go = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_CLEAR;
      end
    endcase
  end

  // ------------------------------------------------------- control regs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      clr_cnt_q   <= '0;
      front_sel_q <= 1'b0;
      swap_done_q <= 1'b0;
      wr_err_q    <= 1'b0;
    end else begin
      clr_cnt_q   <= (state_q == ST_CLEAR) ? clr_cnt_q + 1'b1 : '0;
      front_sel_q <= swap_go ? ~front_sel_q : front_sel_q;
      swap_done_q <= swap_go;
      wr_err_q    <= wr_accept && !wr_in_range;
    end
  end

  // ---------------------------------------------------------- write path
  assign wr_accept   = wr_valid_i && wr_ready_o;
  assign wr_in_range = {1'b0, wr_addr_i} < LIMIT;
  assign host_we     = wr_accept && wr_in_range;

  // Clear writes both banks; host writes only reach the bank not on display.
  assign bank0_we = clear_we || (host_we && front_sel_q);
  assign bank1_we = clear_we || (host_we && !front_sel_q);
  assign waddr    = clear_we ? clr_cnt_q[IDX_W-1:0] : wr_addr_i[IDX_W-1:0];
  assign wdata    = clear_we ? '0 : {wr_g_i, wr_r_i, wr_b_i};

  always_ff @(posedge clk_i) begin
    if (bank0_we) begin
      bank0_mem[waddr] <= wdata;
    end
    if (bank1_we) begin
      bank1_mem[waddr] <= wdata;
    end
  end

  // ----------------------------------------------------------- read path
  assign drv_in_range = {1'b0, drv_address_i} < LIMIT;
  assign raddr        = drv_address_i[IDX_W-1:0];
  assign rd_word      = front_sel_q ? bank1_mem[raddr] : bank0_mem[raddr];

  // Out-of-range addresses and the clear phase return black; the truncated
  // index used above is only meaningful when drv_in_range holds.
  always_ff @(posedge clk_i) begin
    if (rst_i || (state_q == ST_CLEAR) || !drv_in_range) begin
      rd_q <= '0;
    end else begin
      rd_q <= rd_word;
    end
  end

  assign g_o         = rd_q[23:16];
  assign r_o         = rd_q[15:8];
  assign b_o         = rd_q[7:0];
  assign front_sel_o = front_sel_q;
  assign swap_done_o = swap_done_q;
  assign wr_err_o    = wr_err_q;

endmodule

// File: tb/tb_ws2812_frame_buffer_ctrl.sv
module tb_ws2812_frame_buffer_ctrl;

  localparam int unsigned LEDS = 8;
  localparam int unsigned AW   = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_valid;
  logic          wr_ready;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_r, wr_g, wr_b;
  logic          wr_err;
  logic          swap_req;
  logic          swap_pending;
  logic          swap_done;
  logic          frame_sync;
  logic [AW-1:0] drv_addr;
  logic [7:0]    r, g, b;
  logic          front_sel;
  logic          init_busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ws2812_frame_buffer_ctrl #(
    .LED_COUNT (LEDS),
    .ADDR_WIDTH(AW)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .wr_valid_i    (wr_valid),
    .wr_ready_o    (wr_ready),
    .wr_addr_i     (wr_addr),
    .wr_r_i        (wr_r),
    .wr_g_i        (wr_g),
    .wr_b_i        (wr_b),
    .wr_err_o      (wr_err),
    .swap_req_i    (swap_req),
    .swap_pending_o(swap_pending),
    .swap_done_o   (swap_done),
    .frame_sync_i  (frame_sync),
    .drv_address_i (drv_addr),
    .r_o           (r),
    .g_o           (g),
    .b_o           (b),
    .front_sel_o   (front_sel),
    .init_busy_o   (init_busy)
  );

  // Colours are written as {r, g, b} in vectors and expectations.
  typedef struct {
    logic          wv;
    logic [AW-1:0] wa;
    logic [23:0]   wrgb;
    logic          sreq;
    logic          fsync;
    logic [AW-1:0] da;
    logic          e_rdy;
    logic          e_pend;
    logic          e_done;
    logic          e_err;
    logic          e_front;
    logic [23:0]   e_rgb;
  } vec_t;

  vec_t vecs[18];

  function automatic vec_t mk(logic wv, logic [AW-1:0] wa, logic [23:0] wrgb,
                              logic sreq, logic fsync, logic [AW-1:0] da,
                              logic e_rdy, logic e_pend, logic e_done,
                              logic e_err, logic e_front, logic [23:0] e_rgb);
    vec_t v;
    v.wv = wv; v.wa = wa; v.wrgb = wrgb; v.sreq = sreq; v.fsync = fsync;
    v.da = da; v.e_rdy = e_rdy; v.e_pend = e_pend; v.e_done = e_done;
    v.e_err = e_err; v.e_front = e_front; v.e_rgb = e_rgb;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    wr_valid = 0; wr_addr = '0; wr_r = '0; wr_g = '0; wr_b = '0;
    swap_req = 0; frame_sync = 0;
  endtask

  // Counts cycles with init_busy high after rst is released; bounded.
  task automatic count_clear(output int n);
    n = 0;
    while (init_busy === 1'b1 && n < 50) begin
      tick();
      swap_req = 0;
      n++;
    end
  endtask

  initial begin
    int n;
    vecs[0]  = mk(1, 3, 24'h123456, 0, 0, 3, 1, 0, 0, 0, 0, 24'h000000);
    vecs[1]  = mk(1, 9, 24'hAABBCC, 0, 0, 3, 1, 0, 0, 1, 0, 24'h000000);
    vecs[2]  = mk(0, 0, 24'h000000, 0, 0, 3, 1, 0, 0, 0, 0, 24'h000000);
    vecs[3]  = mk(0, 0, 24'h000000, 1, 1, 3, 0, 1, 0, 0, 0, 24'h000000);
    vecs[4]  = mk(0, 0, 24'h000000, 0, 0, 3, 0, 1, 0, 0, 0, 24'h000000);
    vecs[5]  = mk(1, 3, 24'hFFFFFF, 0, 0, 3, 0, 1, 0, 0, 0, 24'h000000);
    vecs[6]  = mk(0, 0, 24'h000000, 0, 1, 3, 1, 0, 1, 0, 1, 24'h000000);
    vecs[7]  = mk(0, 0, 24'h000000, 0, 0, 3, 1, 0, 0, 0, 1, 24'h123456);
    vecs[8]  = mk(0, 0, 24'h000000, 0, 0, 9, 1, 0, 0, 0, 1, 24'h000000);
    vecs[9]  = mk(0, 0, 24'h000000, 0, 0, 1, 1, 0, 0, 0, 1, 24'h000000);
    vecs[10] = mk(1, 3, 24'hFFFFFF, 0, 0, 3, 1, 0, 0, 0, 1, 24'h123456);
    vecs[11] = mk(0, 0, 24'h000000, 0, 0, 3, 1, 0, 0, 0, 1, 24'h123456);
    vecs[12] = mk(1, 0, 24'h010203, 1, 0, 3, 0, 1, 0, 0, 1, 24'h123456);
    vecs[13] = mk(0, 0, 24'h000000, 0, 0, 3, 0, 1, 0, 0, 1, 24'h123456);
    vecs[14] = mk(0, 0, 24'h000000, 0, 1, 3, 1, 0, 1, 0, 0, 24'h123456);
    vecs[15] = mk(0, 0, 24'h000000, 0, 0, 3, 1, 0, 0, 0, 0, 24'hFFFFFF);
    vecs[16] = mk(0, 0, 24'h000000, 0, 0, 0, 1, 0, 0, 0, 0, 24'h010203);
    vecs[17] = mk(0, 0, 24'h000000, 0, 1, 0, 1, 0, 0, 0, 0, 24'h010203);

    // Reset state
    rst = 1; drv_addr = '0;
    idle_inputs();
    repeat (3) tick();
    check("rst_busy", 32'(init_busy), 1);
    check("rst_ready", 32'(wr_ready), 0);
    check("rst_pending", 32'(swap_pending), 0);
    check("rst_done", 32'(swap_done), 0);
    check("rst_err", 32'(wr_err), 0);
    check("rst_front", 32'(front_sel), 0);
    check("rst_rgb", {8'h0, r, g, b}, 0);

    // Clear runs exactly LEDS cycles
    rst = 0;
    count_clear(n);
    check("clear_len", 32'(n), LEDS);
    check("clear_ready", 32'(wr_ready), 1);
    for (int i = 0; i < int'(LEDS); i++) begin
      drv_addr = AW'(i);
      tick();
      check($sformatf("clear_rd%0d", i), {8'h0, r, g, b}, 0);
    end

    // Table-driven sequence
    for (int i = 0; i < 18; i++) begin
      wr_valid   = vecs[i].wv;
      wr_addr    = vecs[i].wa;
      {wr_r, wr_g, wr_b} = vecs[i].wrgb;
      swap_req   = vecs[i].sreq;
      frame_sync = vecs[i].fsync;
      drv_addr   = vecs[i].da;
      tick();
      check($sformatf("v%0d_ready", i), 32'(wr_ready), 32'(vecs[i].e_rdy));
      check($sformatf("v%0d_pend", i), 32'(swap_pending), 32'(vecs[i].e_pend));
      check($sformatf("v%0d_done", i), 32'(swap_done), 32'(vecs[i].e_done));
      check($sformatf("v%0d_err", i), 32'(wr_err), 32'(vecs[i].e_err));
      check($sformatf("v%0d_front", i), 32'(front_sel), 32'(vecs[i].e_front));
      check($sformatf("v%0d_rgb", i), {8'h0, r, g, b}, {8'h0, vecs[i].e_rgb});
    end
    idle_inputs();

    // Reset while a swap is pending, with front bank 1 on display
    swap_req = 1; tick(); swap_req = 0;
    frame_sync = 1; tick(); frame_sync = 0;
    check("pre_front", 32'(front_sel), 1);
    swap_req = 1; tick(); swap_req = 0;
    check("pre_pending", 32'(swap_pending), 1);
    rst = 1; tick();
    check("mid_rst_pending", 32'(swap_pending), 0);
    check("mid_rst_front", 32'(front_sel), 0);
    check("mid_rst_busy", 32'(init_busy), 1);
    check("mid_rst_ready", 32'(wr_ready), 0);
    rst = 0;
    swap_req = 1;  // must be ignored during clear
    count_clear(n);
    check("reclear_len", 32'(n), LEDS);
    check("reclear_pending", 32'(swap_pending), 0);
    check("reclear_ready", 32'(wr_ready), 1);
    frame_sync = 1; drv_addr = 3; tick(); frame_sync = 0;
    check("post_sync_front", 32'(front_sel), 0);
    check("post_sync_done", 32'(swap_done), 0);
    tick();
    check("reclear_rd3", {8'h0, r, g, b}, 0);
    drv_addr = 0; tick();
    check("reclear_rd0", {8'h0, r, g, b}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
